// File: rtl/spi_sck_sequencer.sv
// SPI frame sequencer: CS_n setup/hold, programmable-rate SCK and per-bit edge strobes.
// Optional frame abort (abort_i/aborted_o) is compiled in with `define SCK_ABORT_EN.
module spi_sck_sequencer #(
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8,
  parameter int CS_GAP = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [CNT_W-1:0] nbits_i,
  input  logic             cpol_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_n_o,
  output logic             sck_o,
  output logic             lead_edge_o,
  output logic             trail_edge_o,
  output logic [CNT_W-1:0] bit_idx_o
`ifdef SCK_ABORT_EN
  ,
  input  logic             abort_i,
  output logic             aborted_o
`endif
);

  localparam int GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEAD  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [DIV_W-1:0] half_cnt_reg, half_cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] nbits_reg, nbits_next;
  logic             cpol_reg, cpol_next;
  logic [CNT_W-1:0] bit_idx_reg, bit_idx_next;
  logic             sck_reg, sck_next;
  logic             cs_n_reg, cs_n_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             lead_reg, lead_next;
  logic             trail_reg, trail_next;

  logic             gap_end;
  logic             half_end;
  logic [CNT_W-1:0] bit_idx_inc;
  logic             final_edge;
  logic             abort_take;

  assign gap_end     = (gap_cnt_reg == GAP_W'(CS_GAP - 1));
  assign half_end    = (half_cnt_reg == div_reg - DIV_W'(1));
  // Compared at CNT_W width so nbits = 2^CNT_W-1 completes without wrapping.
  assign bit_idx_inc = bit_idx_reg + CNT_W'(1);
  assign final_edge  = (state_reg == RUN) && half_end && (sck_reg != cpol_reg) &&
                       (bit_idx_inc == nbits_reg);

`ifdef SCK_ABORT_EN
  // A final trailing edge in the same cycle wins over the abort request.
  assign abort_take = abort_i &&
                      ((state_reg == LEAD) || ((state_reg == RUN) && !final_edge));
`else
  assign abort_take = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    gap_cnt_next  = gap_cnt_reg;
    half_cnt_next = half_cnt_reg;
    div_next      = div_reg;
    nbits_next    = nbits_reg;
    cpol_next     = cpol_reg;
    bit_idx_next  = bit_idx_reg;
    sck_next      = sck_reg;
    cs_n_next     = cs_n_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    lead_next     = 1'b0;
    trail_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i && (nbits_i != '0)) begin
          div_next     = (div_i == '0) ? DIV_W'(1) : div_i;
          nbits_next   = nbits_i;
          cpol_next    = cpol_i;
          bit_idx_next = '0;
          sck_next     = cpol_i;
          cs_n_next    = 1'b0;
          busy_next    = 1'b1;
          gap_cnt_next = '0;
          state_next   = LEAD;
        end
      end
      LEAD: begin
        if (abort_take) begin
          gap_cnt_next = '0;
          state_next   = TRAIL;
        end else if (gap_end) begin
          half_cnt_next = '0;
          state_next    = RUN;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      RUN: begin
        if (abort_take) begin
          sck_next     = cpol_reg;
          gap_cnt_next = '0;
          state_next   = TRAIL;
        end else if (half_end) begin
          half_cnt_next = '0;
          if (sck_reg == cpol_reg) begin
            sck_next  = ~cpol_reg;
            lead_next = 1'b1;
          end else begin
            sck_next     = cpol_reg;
            trail_next   = 1'b1;
            bit_idx_next = bit_idx_inc;
            if (final_edge) begin
              gap_cnt_next = '0;
              state_next   = TRAIL;
            end
          end
        end else begin
          half_cnt_next = half_cnt_reg + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (gap_end) begin
          cs_n_next  = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg    <= IDLE;
      gap_cnt_reg  <= '0;
      half_cnt_reg <= '0;
      div_reg      <= DIV_W'(1);
      nbits_reg    <= '0;
      cpol_reg     <= 1'b0;
      bit_idx_reg  <= '0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      lead_reg     <= 1'b0;
      trail_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gap_cnt_reg  <= gap_cnt_next;
      half_cnt_reg <= half_cnt_next;
      div_reg      <= div_next;
      nbits_reg    <= nbits_next;
      cpol_reg     <= cpol_next;
      bit_idx_reg  <= bit_idx_next;
      sck_reg      <= sck_next;
      cs_n_reg     <= cs_n_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      lead_reg     <= lead_next;
      trail_reg    <= trail_next;
    end
  end

`ifdef SCK_ABORT_EN
  logic abort_seen_reg;
  logic aborted_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      abort_seen_reg <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      if (abort_take) begin
        abort_seen_reg <= 1'b1;
      end else if (state_reg == DONE) begin
        abort_seen_reg <= 1'b0;
      end
      aborted_reg <= done_next && abort_seen_reg;
    end
  end

  assign aborted_o = aborted_reg;
`endif

  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign cs_n_o       = cs_n_reg;
  assign sck_o        = sck_reg;
  assign lead_edge_o  = lead_reg;
  assign trail_edge_o = trail_reg;
  assign bit_idx_o    = bit_idx_reg;

endmodule

// File: tb/tb_spi_sck_sequencer.sv
// Directed testbench for spi_sck_sequencer (default build, abort scenario under SCK_ABORT_EN).
module tb_spi_sck_sequencer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] div_i;
  logic [7:0]  nbits_i;
  logic        cpol_i;
  logic        busy_o;
  logic        done_o;
  logic        cs_n_o;
  logic        sck_o;
  logic        lead_edge_o;
  logic        trail_edge_o;
  logic [7:0]  bit_idx_o;
`ifdef SCK_ABORT_EN
  logic        abort_i;
  logic        aborted_o;
`endif

  int checks   = 0;
  int failures = 0;

  // frame statistics gathered by run_frame
  int busy_cycles, cs_low, lead_cnt, trail_cnt, rise_cnt, fall_cnt, high_cnt;
  int done_cnt, strobe_bad, timed_out;
  logic hist[$];

  always #5 clk_in = ~clk_in;

  spi_sck_sequencer #(.DIV_W(16), .CNT_W(8), .CS_GAP(2)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .start_i      (start_i),
    .div_i        (div_i),
    .nbits_i      (nbits_i),
    .cpol_i       (cpol_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cs_n_o       (cs_n_o),
    .sck_o        (sck_o),
    .lead_edge_o  (lead_edge_o),
    .trail_edge_o (trail_edge_o),
    .bit_idx_o    (bit_idx_o)
`ifdef SCK_ABORT_EN
    ,
    .abort_i      (abort_i),
    .aborted_o    (aborted_o)
`endif
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Starts one frame from IDLE and collects per-cycle statistics until two cycles after done_o.
  task automatic run_frame(input logic [15:0] div, input logic [7:0] nbits, input logic cpol,
                           input int limit);
    int   post;
    logic prev_busy;
    logic prev_sck;
    busy_cycles = 0; cs_low = 0; lead_cnt = 0; trail_cnt = 0; rise_cnt = 0; fall_cnt = 0;
    high_cnt = 0; done_cnt = 0; strobe_bad = 0; timed_out = 1;
    hist.delete();
    post = 0; prev_busy = 1'b0; prev_sck = 1'b0;
    div_i = div; nbits_i = nbits; cpol_i = cpol; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (busy_o) begin
        busy_cycles++;
        hist.push_back(sck_o);
        if (sck_o) high_cnt++;
      end
      if (!cs_n_o) cs_low++;
      if (lead_edge_o) lead_cnt++;
      if (trail_edge_o) trail_cnt++;
      if (busy_o && prev_busy) begin
        if (!prev_sck && sck_o) rise_cnt++;
        if (prev_sck && !sck_o) fall_cnt++;
        if (lead_edge_o !== (prev_sck == cpol && sck_o != cpol)) strobe_bad++;
        if (trail_edge_o !== (prev_sck != cpol && sck_o == cpol)) strobe_bad++;
      end else if (lead_edge_o || trail_edge_o) begin
        strobe_bad++;
      end
      if (done_o) done_cnt++;
      if (done_cnt > 0) post++;
      if (post == 3) begin
        timed_out = 0;
        break;
      end
      prev_busy = busy_o;
      prev_sck  = sck_o;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({cs_n_o, sck_o, busy_o, done_o, lead_edge_o, trail_edge_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outputs: got cs_n,sck,busy,done,lead,trail=%b expected 100000",
               {cs_n_o, sck_o, busy_o, done_o, lead_edge_o, trail_edge_o});
    end
    checks++;
    if (bit_idx_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || cs_n_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b cs_n=%b expected 0/1", busy_o, cs_n_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    run_frame(16'd2, 8'd8, 1'b0, 200);
    checks++;
    if (timed_out != 0) begin
      failures++;
      $display("FAIL basic_timeout: got no done_o within 200 cycles expected done_o");
    end
    checks++;
    if (busy_cycles != 36) begin
      failures++;
      $display("FAIL basic_busy: got %0d cycles expected 36", busy_cycles);
    end
    checks++;
    if (cs_low != 36) begin
      failures++;
      $display("FAIL basic_cs_low: got %0d cycles expected 36", cs_low);
    end
    checks++;
    if (rise_cnt != 8 || fall_cnt != 8) begin
      failures++;
      $display("FAIL basic_edges: got rise=%0d fall=%0d expected 8/8", rise_cnt, fall_cnt);
    end
    checks++;
    if (high_cnt != 16) begin
      failures++;
      $display("FAIL basic_sck_high: got %0d cycles expected 16", high_cnt);
    end
    checks++;
    if (lead_cnt != 8 || trail_cnt != 8 || strobe_bad != 0) begin
      failures++;
      $display("FAIL basic_strobes: got lead=%0d trail=%0d bad=%0d expected 8/8/0",
               lead_cnt, trail_cnt, strobe_bad);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done: got %0d pulses expected 1", done_cnt);
    end
    checks++;
    if (bit_idx_o !== 8'd8) begin
      failures++;
      $display("FAIL basic_bit_idx: got %0d expected 8", bit_idx_o);
    end
    $display("test_basic_frame: busy=%0d rise=%0d fall=%0d bit_idx=%0d",
             busy_cycles, rise_cnt, fall_cnt, bit_idx_o);
  endtask

  task automatic test_cpol1_div0();
    logic [5:0] obs;
    obs = 6'b000000;
    run_frame(16'd0, 8'd1, 1'b1, 50);
    for (int i = 0; i < hist.size() && i < 6; i++) obs[5-i] = hist[i];
    checks++;
    if (busy_cycles != 6) begin
      failures++;
      $display("FAIL cpol1_busy: got %0d cycles expected 6", busy_cycles);
    end
    checks++;
    if (obs !== 6'b111011) begin
      failures++;
      $display("FAIL cpol1_sck_seq: got %b expected 111011", obs);
    end
    checks++;
    if (lead_cnt != 1 || trail_cnt != 1 || strobe_bad != 0) begin
      failures++;
      $display("FAIL cpol1_strobes: got lead=%0d trail=%0d bad=%0d expected 1/1/0",
               lead_cnt, trail_cnt, strobe_bad);
    end
    checks++;
    if (done_cnt != 1 || bit_idx_o !== 8'd1) begin
      failures++;
      $display("FAIL cpol1_done: got done=%0d bit_idx=%0d expected 1/1", done_cnt, bit_idx_o);
    end
    $display("test_cpol1_div0: busy=%0d sck=%b", busy_cycles, obs);
  endtask

  task automatic test_nbits_zero();
    int activity;
    activity = 0;
    div_i = 16'd1; nbits_i = 8'd0; cpol_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy_o || !cs_n_o || done_o) activity++;
    end
    start_i = 1'b0;
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL nbits_zero: got %0d active cycles expected 0", activity);
    end
    $display("test_nbits_zero: active_cycles=%0d", activity);
  endtask

  task automatic test_back_to_back();
    int   busy_sum;
    int   dones;
    logic busy_at[16];
    busy_sum = 0; dones = 0;
    div_i = 16'd1; nbits_i = 8'd1; cpol_i = 1'b0; start_i = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      busy_at[i] = busy_o;
      if (busy_o) busy_sum++;
      if (done_o) dones++;
      if (i == 15) start_i = 1'b0;
      step();
    end
    checks++;
    if (dones != 2 || busy_sum != 12) begin
      failures++;
      $display("FAIL b2b_counts: got done=%0d busy=%0d expected 2/12", dones, busy_sum);
    end
    checks++;
    if (busy_at[6] !== 1'b0 || busy_at[7] !== 1'b0 || busy_at[8] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got busy[6..8]=%b%b%b expected 001",
               busy_at[6], busy_at[7], busy_at[8]);
    end
    repeat (10) step();
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_settle: got busy=%b expected 0", busy_o);
    end
    $display("test_back_to_back: done=%0d busy_cycles=%0d", dones, busy_sum);
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    dones = 0;
    div_i = 16'd4; nbits_i = 8'd8; cpol_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (11) step();
    checks++;
    if (sck_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got sck=%b busy=%b expected 1/1", sck_o, busy_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({cs_n_o, sck_o, busy_o, done_o} !== 4'b1000 || bit_idx_o !== 8'd0) begin
      failures++;
      $display("FAIL midrst_post: got cs_n,sck,busy,done=%b bit_idx=%0d expected 1000/0",
               {cs_n_o, sck_o, busy_o, done_o}, bit_idx_o);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o || busy_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midrst_quiet: got %0d active cycles expected 0", dones);
    end
    $display("test_reset_mid_frame done");
  endtask

`ifdef SCK_ABORT_EN
  task automatic test_abort();
    div_i = 16'd2; nbits_i = 8'd8; cpol_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (15) step();
    checks++;
    if (bit_idx_o !== 8'd3) begin
      failures++;
      $display("FAIL abort_pre_idx: got %0d expected 3", bit_idx_o);
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    checks++;
    if (sck_o !== 1'b0 || lead_edge_o !== 1'b0 || trail_edge_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_trail0: got sck=%b lead=%b trail=%b busy=%b expected 0/0/0/1",
               sck_o, lead_edge_o, trail_edge_o, busy_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b1 || cs_n_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_trail1: got busy=%b cs_n=%b expected 1/0", busy_o, cs_n_o);
    end
    step();
    checks++;
    if (done_o !== 1'b1 || aborted_o !== 1'b1 || busy_o !== 1'b0 || bit_idx_o !== 8'd3) begin
      failures++;
      $display("FAIL abort_done: got done=%b aborted=%b busy=%b bit_idx=%0d expected 1/1/0/3",
               done_o, aborted_o, busy_o, bit_idx_o);
    end
    step();
    $display("test_abort done");
  endtask
`endif

  task automatic test_wide_div();
    int rise_at;
    logic lead_at;
    rise_at = -1; lead_at = 1'b0;
    div_i = 16'hFFFF; nbits_i = 8'd1; cpol_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (sck_o) begin
        rise_at = i;
        lead_at = lead_edge_o;
        break;
      end
      step();
    end
    checks++;
    if (rise_at != 65537 || lead_at !== 1'b1) begin
      failures++;
      $display("FAIL wide_div_rise: got first rise at %0d lead=%b expected 65537/1",
               rise_at, lead_at);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    $display("test_wide_div: first rise at cycle %0d", rise_at);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; div_i = '0; nbits_i = '0; cpol_i = 1'b0;
`ifdef SCK_ABORT_EN
    abort_i = 1'b0;
`endif
    test_reset();
    test_basic_frame();
    test_cpol1_div0();
    test_nbits_zero();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SCK_ABORT_EN
    test_abort();
`endif
    test_wide_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
